// File: rtl/dbg_trace_top.sv
// dbg_trace_top: run/halt/step control plus circular multi-channel trace buffer with age-indexed readback.
module dbg_trace_top #(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iRun,
  input  logic                       iHalt,
  input  logic                       iStep,
  input  logic [CHANNELS*DATA_W-1:0] iProbe,
  input  logic [ADDR_W-1:0]          iRdIdx,
  input  logic [CH_W-1:0]            iRdCh,
  output logic                       oCpuEn,
  output logic [1:0]                 oState,
  output logic [DATA_W-1:0]          oRdData,
  output logic [ADDR_W:0]            oCount,
  output logic                       oWrap,
  output logic [31:0]                oCycle
);
  typedef enum logic [1:0] {S_HALT = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2} state_t;
  state_t                      r_state, w_state_nxt;
  logic [CHANNELS*DATA_W-1:0]  r_buf [DEPTH];
  logic [ADDR_W-1:0]           r_wptr, w_slot;
  logic [ADDR_W:0]             r_count;
  logic                        r_wrap, w_full, w_ok;
  logic [31:0]                 r_cycle;
  logic [DATA_W-1:0]           r_rd, w_sel;
  logic [CHANNELS*DATA_W-1:0]  w_word;
  always_comb begin
    w_state_nxt = (r_state == S_STEP || iHalt) ? S_HALT :
                  (r_state == S_RUN) ? S_RUN :
                  iStep ? S_STEP : iRun ? S_RUN : S_HALT;
  end
  assign oCpuEn = (r_state != S_HALT);
  assign oState = r_state;
  assign w_full = (r_count == (ADDR_W+1)'(DEPTH));
  // age 0 is the oldest entry, which sits count slots behind the write pointer
  assign w_slot = r_wptr - r_count[ADDR_W-1:0] + iRdIdx;
  assign w_word = r_buf[w_slot];
  assign w_ok   = ({1'b0, iRdIdx} < r_count);
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (iRdCh == CH_W'(k)) w_sel = w_word[k*DATA_W +: DATA_W];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_HALT;
      r_wptr  <= '0;
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_cycle <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rd    <= w_ok ? w_sel : '0;
      if (oCpuEn) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= w_full ? r_count : r_count + 1'b1;
        r_wrap  <= r_wrap | w_full;
        r_cycle <= r_cycle + 32'd1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (oCpuEn && !reset) r_buf[r_wptr] <= iProbe;
  end
  assign oRdData = r_rd;
  assign oCount  = r_count;
  assign oWrap   = r_wrap;
  assign oCycle  = r_cycle;
endmodule
